pmodad1_capture: RTL and testbench
==================================

// Module: pmodad1_capture
// PURPOSE
//   Serial front end for the PmodAD1 (dual AD7476, 12-bit). On each start request it
//   runs one conversion: drops cs_n, drives 16 SCLK cycles and shifts in both SDATA
//   lines at the same time. It then presents two zero-extended 16-bit words with a
//   one-cycle data_valid strobe. Sits directly upstream of the display stage and
//   drives its data_ch1/data_ch2 inputs.
// PARAMETERS
//   CLK_DIV       4   clk cycles per SCLK half-period (>=2); 100 MHz clk -> 12.5 MHz SCLK
//   QUIET_CYCLES  8   clk cycles with cs_n high after each conversion (>=1; AD7476 tQUIET)
// PORTS
//   clk         in   1   system clock; all logic on rising edge
//   rst         in   1   asynchronous, active-high reset
//   start       in   1   request one conversion; sampled only in IDLE
//   sdata1      in   1   serial data, ADC channel 1 (PmodAD1 D0)
//   sdata2      in   1   serial data, ADC channel 2 (PmodAD1 D1)
//   cs_n        out  1   ADC chip select, active low
//   sclk        out  1   ADC serial clock, idles high
//   busy        out  1   high whenever state != IDLE
//   data_ch1    out  16  last channel-1 result, {4'b0, sample[11:0]}
//   data_ch2    out  16  last channel-2 result, {4'b0, sample[11:0]}
//   data_valid  out  1   one-cycle strobe: data_ch1/2 and fmt_err just updated
//   fmt_err     out  1   last conversion had a nonzero leading bit [15:12] on either channel
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, cs_n=1, sclk=1, busy=0.
//   Also data_ch1=data_ch2=16'h0000, data_valid=0, fmt_err=0, and all counters/shift regs 0.
// - All outputs are registered. sdata1/2 pass through one input flop (sd1_q/sd2_q) before use.
// - FSM: IDLE -> CONV -> DONE -> QUIET -> IDLE.
//   IDLE : cs_n=1, sclk=1. start=1 -> CONV; cs_n=0 from the next cycle; div_cnt=0, bit_cnt=0.
//   CONV : div_cnt counts 0..2*CLK_DIV-1 and wraps.
//          sclk=0 while div_cnt<CLK_DIV, else 1. One bit = 2*CLK_DIV clk cycles.
//          When div_cnt==2*CLK_DIV-1 (last cycle of SCLK high):
//            sr1<={sr1[14:0],sd1_q}, sr2<={sr2[14:0],sd2_q}, bit_cnt++.
//          After the shift for bit_cnt==15 -> DONE. CONV lasts exactly 32*CLK_DIV cycles.
//          That is exactly 16 SCLK rising edges, with MSB first.
//   DONE : 1 cycle, cs_n=1, sclk=1.
//          Loads data_ch1<={4'b0,sr1[11:0]} and data_ch2<={4'b0,sr2[11:0]}.
//          Loads fmt_err<=|{sr1[15:12],sr2[15:12]}. Asserts data_valid for exactly this cycle.
//          -> QUIET.
//   QUIET: cs_n=1, sclk=1. Counts QUIET_CYCLES cycles -> IDLE.
// - Latency: start sampled high in IDLE at cycle 0.
//   cs_n low cycles 1..32*CLK_DIV; data_valid high at cycle 32*CLK_DIV+1 (129 at default).
// - start in CONV/DONE/QUIET is ignored and not queued.
//   With start held high, conversions repeat every 32*CLK_DIV+QUIET_CYCLES+2 cycles
//   (138 at default).
// - data_ch1/2 and fmt_err hold their value between data_valid strobes.
//   No data_valid is produced for an aborted conversion.
// - Reset mid-conversion: cs_n and sclk go high immediately and the partial shift data
//   is discarded. The first start after reset release runs a full, correct conversion.
// - Bits [15:12] of data_ch1/2 are always 0, whatever the ADC drives.
// TESTING
// 1 Reset with outputs toggling -> cs_n=1, sclk=1, busy=0, data_ch1/2=0, data_valid=0, fmt_err=0.
// 2 ADC model (drives on SCLK fall) ch1=0x0ABC, ch2=0x0123; start pulse at cycle 0 ->
//   16 sclk rises, data_valid only at cycle 129, data_ch1=0x0ABC, data_ch2=0x0123, fmt_err=0.
// 3 Extremes: ch1=0x0FFF, ch2=0x0000, then swapped -> exact values returned, no bit slip.
// 4 Model drives ch1=0xFABC, ch2=0x0123 -> data_ch1=0x0ABC, data_ch2=0x0123, fmt_err=1;
//   next clean conversion -> fmt_err=0.
// 5 start held high, then start pulses while busy=1 -> data_valid every 138 cycles;
//   mid-conversion pulses cause no extra conversion.
// 6 rst asserted during bit 7 -> cs_n=1, sclk=1 before the next clk edge, no data_valid;
//   new start after release -> correct 0x0555/0x0AAA result.

Source files
------------

// File: rtl/pmodad1_capture.sv
// Capture front end for the PmodAD1 (dual AD7476). Each start runs one 16-SCLK frame,
// shifting both SDATA lines MSB first, then strobes two zero-extended 12-bit results.
module pmodad1_capture #(
    parameter int CLK_DIV      = 4,
    parameter int QUIET_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sdata1,
    input  logic        sdata2,
    output logic        cs_n,
    output logic        sclk,
    output logic        busy,
    output logic [15:0] data_ch1,
    output logic [15:0] data_ch2,
    output logic        data_valid,
    output logic        fmt_err
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int QW    = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
    localparam logic [QW-1:0]    Q_LAST   = QW'(QUIET_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE,
        QUIET
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [3:0]       bit_cnt_q;
    logic [QW-1:0]    quiet_cnt_q;
    logic             sd1_q;
    logic             sd2_q;
    // Only 15 bits are stored: the 16th shift goes straight into the result registers.
    logic [14:0]      sr1_q;
    logic [14:0]      sr2_q;
    logic             cs_n_q;
    logic             sclk_q;
    logic             busy_q;
    logic [15:0]      data_ch1_q;
    logic [15:0]      data_ch2_q;
    logic             data_valid_q;
    logic             fmt_err_q;

    logic [DIV_W-1:0] div_cnt_d;
    logic [15:0]      sr1_d;
    logic [15:0]      sr2_d;

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        sr1_d     = {sr1_q, sd1_q};
        sr2_d     = {sr2_q, sd2_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            quiet_cnt_q  <= '0;
            sd1_q        <= 1'b0;
            sd2_q        <= 1'b0;
            sr1_q        <= '0;
            sr2_q        <= '0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b1;
            busy_q       <= 1'b0;
            data_ch1_q   <= '0;
            data_ch2_q   <= '0;
            data_valid_q <= 1'b0;
            fmt_err_q    <= 1'b0;
        end else begin
            sd1_q        <= sdata1;
            sd2_q        <= sdata2;
            data_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= CONV;
                        cs_n_q    <= 1'b0;
                        sclk_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                CONV: begin
                    div_cnt_q <= div_cnt_d;
                    sclk_q    <= (div_cnt_d >= DIV_HALF);
                    if (div_cnt_q == DIV_LAST) begin
                        sr1_q     <= sr1_d[14:0];
                        sr2_q     <= sr2_d[14:0];
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        // Results are registered on the edge into DONE so they and the
                        // strobe are visible during the DONE cycle itself.
                        if (bit_cnt_q == 4'd15) begin
                            state_q      <= DONE;
                            cs_n_q       <= 1'b1;
                            sclk_q       <= 1'b1;
                            data_ch1_q   <= {4'b0000, sr1_d[11:0]};
                            data_ch2_q   <= {4'b0000, sr2_d[11:0]};
                            fmt_err_q    <= |{sr1_d[15:12], sr2_d[15:12]};
                            data_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q     <= QUIET;
                    quiet_cnt_q <= '0;
                end
                QUIET: begin
                    if (quiet_cnt_q == Q_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        quiet_cnt_q <= quiet_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cs_n       = cs_n_q;
    assign sclk       = sclk_q;
    assign busy       = busy_q;
    assign data_ch1   = data_ch1_q;
    assign data_ch2   = data_ch2_q;
    assign data_valid = data_valid_q;
    assign fmt_err    = fmt_err_q;

endmodule

// File: tb/tb_pmodad1_capture.sv
// Directed bench for pmodad1_capture with a two-channel ADC model driving on SCLK fall.
module tb_pmodad1_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sdata1;
    logic        sdata2;
    logic        cs_n;
    logic        sclk;
    logic        busy;
    logic [15:0] data_ch1;
    logic [15:0] data_ch2;
    logic        data_valid;
    logic        fmt_err;

    int          checks   = 0;
    int          failures = 0;
    int          rises    = 0;
    logic [15:0] m1 = 16'h0000;
    logic [15:0] m2 = 16'h0000;
    int          idx = 0;
    logic        prev_sclk = 1'b1;

    pmodad1_capture #(
        .CLK_DIV      (4),
        .QUIET_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sdata1     (sdata1),
        .sdata2     (sdata2),
        .cs_n       (cs_n),
        .sclk       (sclk),
        .busy       (busy),
        .data_ch1   (data_ch1),
        .data_ch2   (data_ch2),
        .data_valid (data_valid),
        .fmt_err    (fmt_err)
    );

    always #5 clk = ~clk;

    // ADC model: next bit (MSB first) appears just after each SCLK fall while selected.
    always @(posedge clk) begin
        #1;
        if (cs_n) begin
            idx = 0;
        end else if (prev_sclk && !sclk && idx < 16) begin
            sdata1 = m1[15-idx];
            sdata2 = m2[15-idx];
            idx++;
        end
        prev_sclk = sclk;
    end

    always @(posedge sclk) begin
        if (!cs_n) rises++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Start pulse in cycle 0; cycle i is observed at the negedge i cycles later.
    task automatic run_conv(input logic [15:0] w1, input logic [15:0] w2,
                            input logic [15:0] e1, input logic [15:0] e2,
                            input logic ee, input string tag);
        int first_dv;
        int dv_cnt;
        int low_cnt;
        m1 = w1;
        m2 = w2;
        @(negedge clk);
        start    = 1'b1;
        rises    = 0;
        first_dv = -1;
        dv_cnt   = 0;
        low_cnt  = 0;
        for (int i = 1; i <= 140; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (data_valid) begin
                dv_cnt++;
                if (first_dv < 0) first_dv = i;
            end
            if (!cs_n) low_cnt++;
        end
        check({tag, "_dv_cycle"}, first_dv, 129);
        check({tag, "_dv_count"}, dv_cnt, 1);
        check({tag, "_csn_low"}, low_cnt, 128);
        check({tag, "_sclk_rises"}, rises, 16);
        check({tag, "_ch1"}, {16'h0, data_ch1}, {16'h0, e1});
        check({tag, "_ch2"}, {16'h0, data_ch2}, {16'h0, e2});
        check({tag, "_fmt_err"}, {31'h0, fmt_err}, {31'h0, ee});
        check({tag, "_busy_end"}, {31'h0, busy}, 32'h0);
        $display("conv %s ch1=%h ch2=%h fmt_err=%0b dv_cycle=%0d", tag, data_ch1, data_ch2,
                 fmt_err, first_dv);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cs_n"}, {31'h0, cs_n}, 32'h1);
        check({tag, "_sclk"}, {31'h0, sclk}, 32'h1);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_dv"}, {31'h0, data_valid}, 32'h0);
        check({tag, "_ch1"}, {16'h0, data_ch1}, 32'h0);
        check({tag, "_ch2"}, {16'h0, data_ch2}, 32'h0);
        check({tag, "_fmt_err"}, {31'h0, fmt_err}, 32'h0);
        $display("reset %s cs_n=%0b sclk=%0b busy=%0b", tag, cs_n, sclk, busy);
    endtask

    initial begin
        int dv_times[$];
        int dv_cnt;
        int dv_seen;

        rst    = 1'b1;
        start  = 1'b0;
        sdata1 = 1'b0;
        sdata2 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_conv(16'h0ABC, 16'h0123, 16'h0ABC, 16'h0123, 1'b0, "basic");

        // Abort a conversion in the SCLK-low phase of bit 7 (cycle 58).
        m1 = 16'h0FFF;
        m2 = 16'h0FFF;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 58; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        check("abort_pre_sclk", {31'h0, sclk}, 32'h0);
        check("abort_pre_cs_n", {31'h0, cs_n}, 32'h0);
        #1 rst = 1'b1;
        #1 check_reset_state("abort");
        dv_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (data_valid) dv_seen++;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (data_valid) dv_seen++;
        end
        check("abort_no_dv", dv_seen, 0);
        run_conv(16'h0555, 16'h0AAA, 16'h0555, 16'h0AAA, 1'b0, "after_rst");

        run_conv(16'h0FFF, 16'h0000, 16'h0FFF, 16'h0000, 1'b0, "ext_a");
        run_conv(16'h0000, 16'h0FFF, 16'h0000, 16'h0FFF, 1'b0, "ext_b");

        run_conv(16'hFABC, 16'h0123, 16'h0ABC, 16'h0123, 1'b1, "fmt_bad");
        run_conv(16'h0ABC, 16'h0123, 16'h0ABC, 16'h0123, 1'b0, "fmt_clean");
        run_conv(16'h0123, 16'h8456, 16'h0123, 16'h0456, 1'b1, "fmt_ch2");

        // start held high: back-to-back conversions every 138 cycles.
        m1 = 16'h0321;
        m2 = 16'h0654;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 420; i++) begin
            @(negedge clk);
            if (data_valid) dv_times.push_back(i);
        end
        start = 1'b0;
        check("held_dv_count", dv_times.size(), 3);
        if (dv_times.size() == 3) begin
            check("held_dv0", dv_times[0], 129);
            check("held_dv1", dv_times[1], 267);
            check("held_dv2", dv_times[2], 405);
        end
        check("held_ch1", {16'h0, data_ch1}, 32'h0321);
        check("held_ch2", {16'h0, data_ch2}, 32'h0654);
        $display("held dv_count=%0d", dv_times.size());
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check("held_drain_busy", {31'h0, busy}, 32'h0);

        // Start pulses while busy must not queue an extra conversion.
        m1 = 16'h0777;
        m2 = 16'h0888;
        @(negedge clk);
        start  = 1'b1;
        dv_cnt = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            start = (i == 50 || i == 129 || i == 135);
            if (data_valid) dv_cnt++;
        end
        start = 1'b0;
        check("busy_pulse_dv_count", dv_cnt, 1);
        check("busy_pulse_idle", {31'h0, busy}, 32'h0);
        check("busy_pulse_ch1", {16'h0, data_ch1}, 32'h0777);
        $display("busy_pulse dv_count=%0d", dv_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
